// File: rtl/spram_bist.sv
// March-style built-in self test for a single-port 32-bit RAM.
// Phases: write P(a), read/verify-and-write ~P(a), read-verify ~P(a).
// All outputs, including the RAM port, are registered from next-state values.
module spram_bist #(
  parameter int unsigned size       = 'h80,
  parameter int unsigned addr_width = $clog2(size) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [addr_width-1:0] fail_addr,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q
);

  localparam int unsigned data_w = 32;
  localparam logic [addr_width-1:0] last_addr = '1;

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_wr    = 3'd1;
  localparam logic [2:0] st_rw_r  = 3'd2;
  localparam logic [2:0] st_rw_w  = 3'd3;
  localparam logic [2:0] st_rd    = 3'd4;
  localparam logic [2:0] st_flush = 3'd5;
  localparam logic [2:0] st_done  = 3'd6;

  // Background pattern: inverted address in the upper half, address in the lower.
  function automatic logic [data_w-1:0] pat(input logic [addr_width-1:0] a);
    logic [15:0] a16;
    a16 = 16'(a);
    return {~a16, a16};
  endfunction

  logic [2:0]            state, state_nxt;
  logic [addr_width-1:0] addr_nxt;
  logic                  rd_valid, rd_valid_nxt;
  logic [addr_width-1:0] rd_addr, rd_addr_nxt;
  logic                  busy_nxt, done_nxt, pass_nxt;
  logic [addr_width-1:0] fail_addr_nxt;
  logic                  ce_nxt;
  logic [3:0]            we_nxt;
  logic [data_w-1:0]     d_nxt;

  // State, address counter, read pipeline and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= st_idle;
      ram_addr  <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      ram_ce    <= 1'b0;
      ram_we    <= 4'h0;
      ram_d     <= '0;
    end else begin
      state     <= state_nxt;
      ram_addr  <= addr_nxt;
      rd_valid  <= rd_valid_nxt;
      rd_addr   <= rd_addr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_addr <= fail_addr_nxt;
      ram_ce    <= ce_nxt;
      ram_we    <= we_nxt;
      ram_d     <= d_nxt;
    end
  end

  // Next-state, compare and next-output decode.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = ram_addr;
    rd_valid_nxt  = 1'b0;
    rd_addr_nxt   = rd_addr;
    pass_nxt      = pass;
    fail_addr_nxt = fail_addr;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    ce_nxt        = 1'b0;
    we_nxt        = 4'h0;
    d_nxt         = '0;

    case (state)
      st_idle, st_done: begin
        if (start) begin
          state_nxt     = st_wr;
          addr_nxt      = '0;
          pass_nxt      = 1'b0;
          fail_addr_nxt = '0;
        end
      end
      st_wr: begin
        if (ram_addr == last_addr) begin
          state_nxt = st_rw_r;
          addr_nxt  = '0;
        end else begin
          addr_nxt = ram_addr + addr_width'(1);
        end
      end
      st_rw_r: state_nxt = st_rw_w;
      st_rw_w: begin
        if (ram_q != pat(ram_addr)) begin
          state_nxt     = st_done;
          fail_addr_nxt = ram_addr;
          pass_nxt      = 1'b0;
          addr_nxt      = '0;
        end else if (ram_addr == last_addr) begin
          state_nxt = st_rd;
          addr_nxt  = '0;
        end else begin
          state_nxt = st_rw_r;
          addr_nxt  = ram_addr + addr_width'(1);
        end
      end
      st_rd: begin
        rd_valid_nxt = 1'b1;
        rd_addr_nxt  = ram_addr;
        if (rd_valid && (ram_q != ~pat(rd_addr))) begin
          state_nxt     = st_done;
          fail_addr_nxt = rd_addr;
          pass_nxt      = 1'b0;
          addr_nxt      = '0;
        end else if (ram_addr == last_addr) begin
          state_nxt = st_flush;
          addr_nxt  = '0;
        end else begin
          addr_nxt = ram_addr + addr_width'(1);
        end
      end
      st_flush: begin
        state_nxt = st_done;
        addr_nxt  = '0;
        if (ram_q != ~pat(rd_addr)) begin
          fail_addr_nxt = rd_addr;
          pass_nxt      = 1'b0;
        end else begin
          pass_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = st_idle;
        addr_nxt  = '0;
      end
    endcase

    case (state_nxt)
      st_wr: begin
        ce_nxt = 1'b1;
        we_nxt = 4'hF;
        d_nxt  = pat(addr_nxt);
      end
      st_rw_r: ce_nxt = 1'b1;
      st_rw_w: begin
        ce_nxt = 1'b1;
        we_nxt = 4'hF;
        d_nxt  = ~pat(addr_nxt);
      end
      st_rd:   ce_nxt = 1'b1;
      default: ce_nxt = 1'b0;
    endcase

    busy_nxt = (state_nxt == st_wr) || (state_nxt == st_rw_r) || (state_nxt == st_rw_w) ||
               (state_nxt == st_rd) || (state_nxt == st_flush);
    done_nxt = (state_nxt == st_done);
  end

endmodule

// File: tb/tb_spram_bist.sv
// Scoreboard bench for spram_bist with a fault-injectable RAM model.
module tb_spram_bist;

  localparam int unsigned aw = 5;
  localparam int unsigned nw = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [aw-1:0] fail_addr;
  logic [aw-1:0] ram_addr;
  logic          ram_ce;
  logic [3:0]    ram_we;
  logic [31:0]   ram_d;
  logic [31:0]   ram_q;

  spram_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .ram_addr  (ram_addr),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_d     (ram_d),
    .ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one optional stuck-at bit applied on write.
  logic [31:0]   mem [nw];
  logic          fault_en;
  logic [aw-1:0] fault_addr;
  int            fault_bit;
  logic          fault_val;
  logic [31:0]   wword;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we != 4'h0) begin
        wword = mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) wword[8*b +: 8] = ram_d[8*b +: 8];
        if (fault_en && ram_addr == fault_addr) wword[fault_bit] = fault_val;
        mem[ram_addr] <= wword;
      end else begin
        ram_q <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic          pass;
    logic [aw-1:0] fail_addr;
    int            cycles;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: counts busy cycles, scores each completed run against the queue.
  int   busy_cnt = 0;
  logic done_q   = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      done_q   = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pass", 32'(pass), 32'(e.pass));
          check("fail_addr", 32'(fail_addr), 32'(e.fail_addr));
          check("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
          check("ce_in_done", {27'd0, ram_ce, ram_we}, 32'd0);
        end
        busy_cnt = 0;
      end
      done_q = done;
    end
  end

  task automatic push_exp(input logic p, input logic [aw-1:0] fa, input int cyc);
    exp_t e;
    e.pass = p;
    e.fail_addr = fa;
    e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault_en = 1'b0;
    fault_addr = '0;
    fault_bit = 0;
    fault_val = 1'b0;
    ram_q = '0;
    for (int i = 0; i < nw; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_pass", {30'd0, done, pass}, 32'd0);
    check("rst_ram", {26'd0, ram_ce, ram_we, ram_addr == '0}, 32'd1);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    rst_n = 1'b1;

    // Fault-free run and first RAM cycle.
    push_exp(1'b1, 5'd0, 129);
    pulse_start();
    check("first_cycle_ctl", {26'd0, ram_ce, ram_we, busy}, {26'd0, 1'b1, 4'hF, 1'b1});
    check("first_cycle_addr", 32'(ram_addr), 32'd0);
    check("first_cycle_d", ram_d, 32'hFFFF0000);
    wait_done(300);
    @(posedge clk); #1;
    check("idle_after_done", {27'd0, ram_ce, ram_we}, 32'd0);

    // Word 5 bit 0 stuck-at-0: caught in RW_W at address 5.
    fault_en = 1'b1; fault_addr = 5'd5; fault_bit = 0; fault_val = 1'b0;
    push_exp(1'b0, 5'd5, 44);
    pulse_start();
    wait_done(300);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_access_after_fail", {27'd0, ram_ce, ram_we}, 32'd0);
    end

    // Word 3 bit 31 stuck-at-1: only the read phase sees it.
    fault_addr = 5'd3; fault_bit = 31; fault_val = 1'b1;
    push_exp(1'b0, 5'd3, 101);
    pulse_start();
    wait_done(300);
    fault_en = 1'b0;

    // Extra start pulse at cycle 40 of a run is ignored.
    push_exp(1'b1, 5'd0, 129);
    pulse_start();
    repeat (39) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(300);

    // start held high: the run restarts the cycle after done.
    push_exp(1'b1, 5'd0, 129);
    push_exp(1'b1, 5'd0, 129);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    wait_done(300);
    @(posedge clk); #1;
    check("restart_done_clear", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(300);

    // Reset during WR at address 10 aborts immediately.
    pulse_start();
    while (!(ram_we == 4'hF && ram_addr == 5'd10)) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_ce", 32'(ram_ce), 32'd0);
    check("abort_flags", {29'd0, busy, done, pass}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_exp(1'b1, 5'd0, 129);
    pulse_start();
    wait_done(300);

    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spram_bist.md
SPRAM_BIST -- requirements
Module: spram_bist

Interface
REQ-001 Parameter size, default 'h80: RAM size in bytes, matching the target single-port RAM.
REQ-002 Parameter addr_width, default $clog2(size)-2: word address width. W = 2**addr_width words (32 at default).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a test run; sampled only in IDLE or DONE.
REQ-006 busy  output  1  test in progress.
REQ-007 done  output  1  test finished; held until the next accepted start or reset.
REQ-008 pass  output  1  valid while done=1: 1 means no mismatch was found.
REQ-009 fail_addr  output  addr_width  word address of the first mismatch; 0 if none.
REQ-010 ram_addr  output  addr_width  RAM word address.
REQ-011 ram_ce  output  1  RAM chip enable.
REQ-012 ram_we  output  4  RAM byte write enables.
REQ-013 ram_d  output  32  RAM write data.
REQ-014 ram_q  input  32  RAM read data, valid 1 cycle after a read (ce=1, we=0).

Function
REQ-015 Pattern P(a) = {~a16, a16}, where a16 is the address zero-extended to 16 bits. Example: P(0)=32'hFFFF0000, P(5)=32'hFFFA0005.
REQ-016 States: IDLE, WR, RW_R, RW_W, RD, FLUSH, DONE. busy=1 in WR, RW_R, RW_W, RD and FLUSH.
REQ-017 IDLE or DONE with start=1: go to WR with address=0, done=0, pass=0 and fail_addr=0.
REQ-018 WR: ram_ce=1, ram_we=4'hF, ram_d=P(addr), address incremented each cycle. At address W-1, go to RW_R with address=0.
REQ-019 RW_R: ram_ce=1, ram_we=0, read at the current address; next state RW_W.
REQ-020 RW_W: ram_ce=1, ram_we=4'hF, ram_d=~P(addr). In the same cycle compare ram_q with P(addr).
REQ-021 RW_W next state: address+1 to RW_R, or, at address W-1, to RD with address=0.
REQ-022 RD: ram_ce=1, ram_we=0, address incremented each cycle. Each read is compared one cycle later against ~P(registered read address). At address W-1, go to FLUSH.
REQ-023 FLUSH: ram_ce=0; compare the final read, then go to DONE.
REQ-024 A run with no mismatch is busy for exactly 4W+1 cycles (129 at default), then DONE with pass=1.
REQ-025 On the first mismatch: fail_addr is loaded with the compared address, pass=0, and the next state is DONE. The test aborts and no further RAM access is issued.
REQ-026 In IDLE and DONE: ram_ce=0, ram_we=0, ram_d=0, ram_addr=0.
REQ-027 start while busy=1 is ignored. start held high in DONE restarts on the next cycle.
REQ-028 Address counting never wraps within a phase. The phase transition at W-1 is mandatory.
REQ-029 All comparisons are full 32-bit equality. Byte-lane partial writes are never issued.

Reset
REQ-030 While rst_n=0: state=IDLE; busy, done, pass, fail_addr, ram_addr, ram_ce, ram_we and ram_d are all 0.
REQ-031 Assertion mid-run deasserts ram_ce asynchronously, with no further write issued.
REQ-032 After rst_n deasserts, the block waits in IDLE for start. No partial-run state survives reset.

Verification
REQ-033 Fault-free RAM model, 1-cycle start pulse -> busy=1 for 129 cycles, then done=1, pass=1, fail_addr=0. The first RAM cycle shows addr=0, we=4'hF, d=32'hFFFF0000.
REQ-034 RAM word 5 bit 0 stuck-at-0 -> mismatch in RW_W at address 5 -> done=1, pass=0, fail_addr=5. No RAM access after that cycle.
REQ-035 RAM word 3 bit 31 stuck-at-1 -> RW phase passes; RD phase sees ~P(3)=32'h0003FFFC mismatch -> pass=0, fail_addr=3.
REQ-036 Second start pulse during busy (cycle 40) -> ignored; the run ends at cycle 129. start held high -> new run begins the cycle after done, with done cleared.
REQ-037 rst_n=0 during WR at address 10 -> ram_ce=0 in the same cycle; busy, done and pass = 0. A later start gives a full 129-cycle run with pass=1.
